syscon_wb_initiator: RTL and testbench

SYSCON_WB_INITIATOR -- requirements
Module: syscon_wb_initiator

---
 rtl/syscon_pkg.sv | 29 ++
 rtl/syscon_wb_initiator.sv | 153 +++++++++++++++
 tb/tb_syscon_wb_initiator.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/syscon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : syscon_pkg
// Purpose  : Shared types and register map for the syscon Wishbone initiator
//            and the syscon register block it talks to.
// Revision : 1.0 - initial release
// ============================================================================
package syscon_pkg;

  // Initiator FSM encoding; IDLE must stay at zero so a cleared register is idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUS  = 2'b01,
    ST_RESP = 2'b10
  } syscon_state_e;

  // Syscon register byte offsets (word aligned).
  localparam logic [7:0] SYSCON_VERSION       = 8'h00;
  localparam logic [7:0] SYSCON_SW_IRQ        = 8'h08;
  localparam logic [7:0] SYSCON_NMI_VEC       = 8'h0C;
  localparam logic [7:0] SYSCON_IRQ_EN        = 8'h18;
  localparam logic [7:0] SYSCON_MTIMECMP      = 8'h28;
  localparam logic [7:0] SYSCON_IRQ_TIMER_CNT = 8'h30;
  localparam logic [7:0] SYSCON_IRQ_TIMER_EN  = 8'h34;
  localparam logic [7:0] SYSCON_SEG_ENABLES   = 8'h38;
  localparam logic [7:0] SYSCON_SEG_DIGITS    = 8'h3C;

endpackage : syscon_pkg
`default_nettype wire

// File: rtl/syscon_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : syscon_wb_initiator
// Purpose  : Turns a valid/ready command into one Wishbone classic cycle and
//            returns the result on a valid/ready response channel. A cycle
//            that is not acknowledged within TIMEOUT_CYCLES is aborted and
//            reported with the error flag.
// Revision : 1.0 - initial release
// ============================================================================
module syscon_wb_initiator
  import syscon_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADR_W          = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,

  // Command channel
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_we,
  input  logic [ADR_W-1:0] i_cmd_adr,
  input  logic [31:0]      i_cmd_dat,
  input  logic [3:0]       i_cmd_sel,

  // Response channel
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [31:0]      o_rsp_dat,
  output logic             o_rsp_err,

  // Wishbone classic initiator
  output logic [ADR_W-1:0] o_wb_adr,
  output logic [31:0]      o_wb_dat,
  output logic [3:0]       o_wb_sel,
  output logic             o_wb_we,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  input  logic [31:0]      i_wb_rdt,
  input  logic             i_wb_ack,

  output logic             o_busy
);

  // One extra bit keeps the terminal count representable for powers of two.
  localparam int unsigned          CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]     TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  syscon_state_e    state_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [ADR_W-1:0] wb_adr_q;
  logic [31:0]      wb_dat_q;
  logic [3:0]       wb_sel_q;
  logic             wb_we_q;
  logic             wb_cyc_q;
  logic             wb_stb_q;
  logic             rsp_valid_q;
  logic [31:0]      rsp_dat_q;
  logic             rsp_err_q;

  logic             w_tmo_last;

  // Terminal count: the last bus cycle the responder is given to acknowledge.
  assign w_tmo_last = (tmo_cnt_q == TMO_LAST);

  // Transaction sequencer: accept, run the bus cycle, hold the response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      tmo_cnt_q   <= '0;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_sel_q    <= '0;
      wb_we_q     <= 1'b0;
      wb_cyc_q    <= 1'b0;
      wb_stb_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Ready is implied by being in IDLE; a zero byte select still
          // produces a cycle and data is passed through untouched.
          if (i_cmd_valid) begin
            wb_adr_q  <= i_cmd_adr;
            wb_dat_q  <= i_cmd_dat;
            wb_sel_q  <= i_cmd_sel;
            wb_we_q   <= i_cmd_we;
            wb_cyc_q  <= 1'b1;
            wb_stb_q  <= 1'b1;
            tmo_cnt_q <= '0;
            state_q   <= ST_BUS;
          end
        end

        ST_BUS: begin
          // Ack wins over a timeout landing in the same cycle.
          if (i_wb_ack) begin
            rsp_dat_q   <= wb_we_q ? 32'h0 : i_wb_rdt;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            state_q     <= ST_RESP;
          end else if (w_tmo_last) begin
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            state_q     <= ST_RESP;
          end else begin
            // Stops at the terminal count, so it never wraps.
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end

        ST_RESP: begin
          // Response data and error are held until the consumer takes them.
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          wb_cyc_q    <= 1'b0;
          wb_stb_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Ready and busy are decoded from the state register alone.
  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);

  assign o_wb_adr    = wb_adr_q;
  assign o_wb_dat    = wb_dat_q;
  assign o_wb_sel    = wb_sel_q;
  assign o_wb_we     = wb_we_q;
  assign o_wb_cyc    = wb_cyc_q;
  assign o_wb_stb    = wb_stb_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_dat   = rsp_dat_q;
  assign o_rsp_err   = rsp_err_q;

endmodule : syscon_wb_initiator
`default_nettype wire

// File: tb/tb_syscon_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_syscon_wb_initiator
// Purpose  : Directed self-checking bench for syscon_wb_initiator driving a
//            small syscon-like register responder with programmable ack delay.
// Revision : 1.0 - initial release
// ============================================================================
module tb_syscon_wb_initiator;

  localparam int unsigned TMO = 8;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [5:0]  cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic [5:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        busy;

  // Responder controls
  logic        ack_en;
  logic        stray_ack;
  int          ack_lat;
  int          resp_cnt;
  logic [31:0] mem [16];

  int n_checks;
  int n_fail;

  syscon_wb_initiator #(
    .TIMEOUT_CYCLES(TMO),
    .ADR_W         (6)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_we   (cmd_we),
    .i_cmd_adr  (cmd_adr),
    .i_cmd_dat  (cmd_dat),
    .i_cmd_sel  (cmd_sel),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_dat  (rsp_dat),
    .o_rsp_err  (rsp_err),
    .o_wb_adr   (wb_adr),
    .o_wb_dat   (wb_dat),
    .o_wb_sel   (wb_sel),
    .o_wb_we    (wb_we),
    .o_wb_cyc   (wb_cyc),
    .o_wb_stb   (wb_stb),
    .i_wb_rdt   (wb_rdt),
    .i_wb_ack   (wb_ack),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: acks when it has seen cyc/stb for ack_lat edges.
  assign wb_ack = (ack_en && wb_cyc && wb_stb && (resp_cnt == ack_lat)) || stray_ack;
  assign wb_rdt = mem[wb_adr[5:2]];

  // Responder wait counter.
  always @(posedge clk) begin
    if (!(wb_cyc && wb_stb)) resp_cnt <= 0;
    else                     resp_cnt <= resp_cnt + 1;
  end

  // Responder register file: reset values, byte-lane writes on ack.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hFF0A_0B0C;
      mem[2] <= 32'h0000_0ABC;
    end else if (wb_ack && wb_cyc && wb_stb && wb_we) begin
      for (int b = 0; b < 4; b++)
        if (wb_sel[b]) mem[wb_adr[5:2]][8*b +: 8] <= wb_dat[8*b +: 8];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one command in IDLE; returns 1ns after the acceptance edge.
  task automatic send_cmd(input logic we, input logic [5:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Counts edges until rsp_valid, and how many of those cycles had cyc high.
  task automatic wait_rsp(output int edges, output int cyc_edges);
    edges = 0;
    cyc_edges = 0;
    while (!rsp_valid && edges < 100) begin
      if (wb_cyc) cyc_edges++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (wb_cyc !== 1'b0)    begin n_fail++; $display("FAIL reset_cyc: got %b want 0", wb_cyc); end
    n_checks++; if (wb_stb !== 1'b0)    begin n_fail++; $display("FAIL reset_stb: got %b want 0", wb_stb); end
    n_checks++; if (wb_we !== 1'b0)     begin n_fail++; $display("FAIL reset_we: got %b want 0", wb_we); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_err !== 1'b0)   begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if (rsp_dat !== 32'h0)  begin n_fail++; $display("FAIL reset_rsp_dat: got %h want 0", rsp_dat); end
    n_checks++; if (wb_adr !== 6'h0 || wb_dat !== 32'h0 || wb_sel !== 4'h0)
      begin n_fail++; $display("FAIL reset_wb_bus: got adr %h dat %h sel %h want 0", wb_adr, wb_dat, wb_sel); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_write();
    int e, c;
    send_cmd(1'b1, 6'h3C, 32'h1234_5678, 4'hF);
    n_checks++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1 || wb_we !== 1'b1)
      begin n_fail++; $display("FAIL wr_strobes: got cyc %b stb %b we %b want 111", wb_cyc, wb_stb, wb_we); end
    n_checks++; if (wb_adr !== 6'h3C || wb_dat !== 32'h1234_5678 || wb_sel !== 4'hF)
      begin n_fail++; $display("FAIL wr_bus: got %h/%h/%h want 3c/12345678/f", wb_adr, wb_dat, wb_sel); end
    n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1)
      begin n_fail++; $display("FAIL wr_busy: got ready %b busy %b want 0 1", cmd_ready, busy); end
    wait_rsp(e, c);
    n_checks++; if (c !== 2) begin n_fail++; $display("FAIL wr_cyc_len: got %0d want 2", c); end
    n_checks++; if (mem[15] !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_reg: got %h want 12345678", mem[15]); end
    n_checks++; if (rsp_err !== 1'b0 || rsp_dat !== 32'h0)
      begin n_fail++; $display("FAIL wr_rsp: got err %b dat %h want 0 0", rsp_err, rsp_dat); end
    tick();
    n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
      begin n_fail++; $display("FAIL wr_return_idle: got ready %b valid %b want 1 0", cmd_ready, rsp_valid); end
  endtask

  task automatic test_read();
    int e, c;
    send_cmd(1'b0, 6'h00, 32'hDEAD_BEEF, 4'hF);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_valid: got %b want 0", rsp_valid); end
    wait_rsp(e, c);
    // Acceptance edge T, ack sampled at T+2, valid visible right after T+2.
    n_checks++; if (e !== 2) begin n_fail++; $display("FAIL rd_latency: got %0d edges after accept want 2", e); end
    n_checks++; if (rsp_dat !== 32'hFF0A_0B0C || rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL rd_rsp: got dat %h err %b want ff0a0b0c 0", rsp_dat, rsp_err); end
    n_checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0)
      begin n_fail++; $display("FAIL rd_cyc_drop: got cyc %b stb %b want 0 0", wb_cyc, wb_stb); end
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready_t3: got %b want 1", cmd_ready); end
  endtask

  task automatic test_readback();
    int e, c;
    send_cmd(1'b0, 6'h3C, 32'h0, 4'hF);
    wait_rsp(e, c);
    n_checks++; if (rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL readback: got dat %h err %b want 12345678 0", rsp_dat, rsp_err); end
    tick();
  endtask

  task automatic test_stray_ack();
    stray_ack = 1'b1;
    tick();
    tick();
    stray_ack = 1'b0;
    n_checks++; if (wb_cyc !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0)
      begin n_fail++; $display("FAIL stray_idle_state: got cyc %b valid %b ready %b busy %b want 0 0 1 0", wb_cyc, rsp_valid, cmd_ready, busy); end
    n_checks++; if (rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL stray_idle_data: got dat %h err %b want 12345678 0", rsp_dat, rsp_err); end
  endtask

  task automatic test_sel_zero();
    int e, c;
    send_cmd(1'b1, 6'h38, 32'hA5A5_A5A5, 4'h0);
    n_checks++; if (wb_cyc !== 1'b1 || wb_sel !== 4'h0 || wb_dat !== 32'hA5A5_A5A5)
      begin n_fail++; $display("FAIL sel0_bus: got cyc %b sel %h dat %h want 1 0 a5a5a5a5", wb_cyc, wb_sel, wb_dat); end
    wait_rsp(e, c);
    n_checks++; if (e !== 2 || rsp_err !== 1'b0 || rsp_dat !== 32'h0)
      begin n_fail++; $display("FAIL sel0_rsp: got edges %0d err %b dat %h want 2 0 0", e, rsp_err, rsp_dat); end
    tick();
  endtask

  task automatic test_timeout();
    int e, c;
    ack_en = 1'b0;
    send_cmd(1'b0, 6'h28, 32'h0, 4'hF);
    wait_rsp(e, c);
    n_checks++; if (c !== 8) begin n_fail++; $display("FAIL tmo_cyc_len: got %0d want 8", c); end
    n_checks++; if (rsp_err !== 1'b1 || rsp_dat !== 32'h0)
      begin n_fail++; $display("FAIL tmo_rsp: got err %b dat %h want 1 0", rsp_err, rsp_dat); end
    n_checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0)
      begin n_fail++; $display("FAIL tmo_drop: got cyc %b stb %b want 0 0", wb_cyc, wb_stb); end
    tick();
    ack_en = 1'b1;
  endtask

  task automatic test_ack_at_timeout();
    int e, c;
    ack_lat = 7;   // ack sampled at the terminal-count edge (T+8)
    send_cmd(1'b0, 6'h08, 32'h0, 4'hF);
    wait_rsp(e, c);
    n_checks++; if (e !== 8) begin n_fail++; $display("FAIL coinc_edges: got %0d want 8", e); end
    n_checks++; if (rsp_err !== 1'b0 || rsp_dat !== 32'h0000_0ABC)
      begin n_fail++; $display("FAIL coinc_rsp: got err %b dat %h want 0 00000abc", rsp_err, rsp_dat); end
    tick();
    ack_lat = 1;
  endtask

  task automatic test_backpressure();
    int e, c;
    int bad;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 6'h00, 32'h0, 4'hF);
    wait_rsp(e, c);
    // Offer a second command and a stray ack while the response is held.
    cmd_we = 1'b1; cmd_adr = 6'h38; cmd_dat = 32'h0000_0055; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    stray_ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'hFF0A_0B0C || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || wb_cyc !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got valid %b dat %h err %b ready %b cyc %b want 1 ff0a0b0c 0 0 0",
                 i, rsp_valid, rsp_dat, rsp_err, cmd_ready, wb_cyc);
      end
      tick();
    end
    stray_ack = 1'b0;
    rsp_ready = 1'b1;
    tick();  // handshake
    n_checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || wb_cyc !== 1'b0)
      begin n_fail++; $display("FAIL bp_release: got ready %b valid %b cyc %b want 1 0 0", cmd_ready, rsp_valid, wb_cyc); end
    tick();  // second command accepted
    cmd_valid = 1'b0;
    n_checks++; if (wb_cyc !== 1'b1 || wb_adr !== 6'h38 || wb_we !== 1'b1)
      begin n_fail++; $display("FAIL bp_second_cmd: got cyc %b adr %h we %b want 1 38 1", wb_cyc, wb_adr, wb_we); end
    wait_rsp(e, c);
    n_checks++; if (e !== 2 || rsp_err !== 1'b0)
      begin n_fail++; $display("FAIL bp_second_rsp: got edges %0d err %b want 2 0", e, rsp_err); end
    tick();
  endtask

  task automatic test_reset_mid_bus();
    int seen;
    ack_en = 1'b0;
    send_cmd(1'b0, 6'h30, 32'h0, 4'hF);
    n_checks++; if (wb_cyc !== 1'b1) begin n_fail++; $display("FAIL rmb_cyc_up: got %b want 1", wb_cyc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_en = 1'b1;
    n_checks++; if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
      begin n_fail++; $display("FAIL rmb_after_reset: got cyc %b stb %b valid %b ready %b want 0 0 0 1", wb_cyc, wb_stb, rsp_valid, cmd_ready); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_cyc || rsp_valid) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rmb_no_retry: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 6'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b1;
    ack_en    = 1'b1;
    ack_lat   = 1;
    stray_ack = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_readback();
    test_stray_ack();
    test_sel_zero();
    test_timeout();
    test_ack_at_timeout();
    test_backpressure();
    test_reset_mid_bus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_syscon_wb_initiator
`default_nettype wire
